// File: rtl/frame_update_sched_pkg.sv
// frame_update_sched_pkg: shared state encoding, unit indices and defaults for the frame scheduler.
package frame_update_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam int UNIT_HERO1   = 0;
    localparam int UNIT_HERO2   = 1;
    localparam int UNIT_COLLIDE = 2;
    localparam int UNIT_SCROLL  = 3;

    localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/frame_update_sched_watchdog.sv
// unit_watchdog: counts WAIT cycles for the current unit and pulses expire on the TIMEOUT-th one.
module unit_watchdog
    import frame_update_sched_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/frame_update_sched.sv
// frame_update_sched: per-vsync input snapshot and sequential start/done scheduling of game update units.
module frame_update_sched
    import frame_update_sched_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int FCW       = 16,
    localparam int IW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 sched_en,
    input  logic [1:0]           btn1,
    input  logic [1:0]           btn2,
    input  logic                 eff,
    input  logic [NUM_UNITS-1:0] done,
    input  logic                 clear_err,
    output logic [NUM_UNITS-1:0] start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FCW-1:0]       frame_cnt,
    output logic [1:0]           btn1_snap,
    output logic [1:0]           btn2_snap,
    output logic                 eff_snap,
    output logic                 overrun,
    output logic [7:0]           ovr_cnt,
    output logic                 timeout_err,
    output logic [IW-1:0]        err_unit
);

    state_t        state;
    logic [IW-1:0] idx;
    logic          vsync_d;
    logic          vs_edge;
    logic          done_cur;
    logic          last;
    logic          expire;

    assign vs_edge  = vsync_d & ~vsync;
    assign done_cur = done[idx];
    assign last     = idx == IW'(NUM_UNITS - 1);
    assign busy     = state != S_IDLE;

    unit_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == S_START),
        .en     (state == S_WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            vsync_d     <= 1'b1;
            start       <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            btn1_snap   <= '0;
            btn2_snap   <= '0;
            eff_snap    <= 1'b0;
            overrun     <= 1'b0;
            ovr_cnt     <= '0;
            timeout_err <= 1'b0;
            err_unit    <= '0;
        end else begin
            vsync_d    <= vsync;
            start      <= '0;
            frame_done <= 1'b0;
            if (clear_err) begin
                overrun     <= 1'b0;
                ovr_cnt     <= '0;
                timeout_err <= 1'b0;
                err_unit    <= '0;
            end
            // set events are written after the clear so they take priority
            if (vs_edge && state != S_IDLE) begin
                overrun <= 1'b1;
                ovr_cnt <= clear_err ? 8'd1 : ovr_cnt + {7'd0, ovr_cnt != 8'hFF};
            end
            case (state)
                S_IDLE: if (vs_edge && sched_en) begin
                    state     <= S_START;
                    idx       <= '0;
                    start     <= NUM_UNITS'(1);
                    btn1_snap <= btn1;
                    btn2_snap <= btn2;
                    eff_snap  <= eff;
                end
                S_START: state <= S_WAIT;
                S_WAIT: if (done_cur || expire) begin
                    if (!done_cur) begin
                        timeout_err <= 1'b1;
                        err_unit    <= idx;
                    end
                    if (last) begin
                        state      <= S_FIN;
                        frame_done <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_START;
                        start <= NUM_UNITS'(1) << (idx + 1'b1);
                    end
                end
                default: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_update_sched.sv
// tb_frame_update_sched: table-driven frame vectors plus directed overrun, reset, saturation and wrap sequences.
module tb_frame_update_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       sched_en = 1'b0;
    logic [1:0] btn1 = '0;
    logic [1:0] btn2 = '0;
    logic       eff = 1'b0;
    logic [3:0] done = '0;
    logic       clear_err = 1'b0;

    logic [3:0]  start;
    logic        busy, frame_done, eff_snap, overrun, timeout_err;
    logic [15:0] frame_cnt;
    logic [1:0]  btn1_snap, btn2_snap, err_unit;
    logic [7:0]  ovr_cnt;

    logic [3:0] s_start;
    logic       s_busy, s_frame_done, s_eff_snap, s_overrun, s_timeout_err;
    logic [3:0] s_frame_cnt;
    logic [1:0] s_btn1_snap, s_btn2_snap, s_err_unit;
    logic [7:0] s_ovr_cnt;

    int total = 0;
    int bad = 0;
    int rc[4];
    logic [3:0] dead = '0;

    always #5 clk = ~clk;

    frame_update_sched #(.NUM_UNITS(4), .TIMEOUT(16), .FCW(16)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .sched_en(sched_en),
        .btn1(btn1), .btn2(btn2), .eff(eff), .done(done), .clear_err(clear_err),
        .start(start), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .btn1_snap(btn1_snap), .btn2_snap(btn2_snap), .eff_snap(eff_snap),
        .overrun(overrun), .ovr_cnt(ovr_cnt), .timeout_err(timeout_err), .err_unit(err_unit)
    );

    // narrow frame counter copy, used to observe wrap-around cheaply
    frame_update_sched #(.NUM_UNITS(4), .TIMEOUT(16), .FCW(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .sched_en(sched_en),
        .btn1(btn1), .btn2(btn2), .eff(eff), .done(done), .clear_err(clear_err),
        .start(s_start), .busy(s_busy), .frame_done(s_frame_done), .frame_cnt(s_frame_cnt),
        .btn1_snap(s_btn1_snap), .btn2_snap(s_btn2_snap), .eff_snap(s_eff_snap),
        .overrun(s_overrun), .ovr_cnt(s_ovr_cnt), .timeout_err(s_timeout_err), .err_unit(s_err_unit)
    );

    typedef struct {
        logic        en;
        logic [1:0]  b1, b2;
        logic        e;
        logic [3:0]  dead;
        logic [1:0]  xb1, xb2;
        logic        xe;
        logic [15:0] xcnt;
        logic [1:0]  xeu;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // one clock; unit i answers done one cycle, three cycles after its start unless marked dead
    task automatic step();
        @(posedge clk);
        #1;
        done = '0;
        for (int i = 0; i < 4; i++) begin
            if (start[i]) rc[i] = 3;
            else if (rc[i] > 0) begin
                rc[i]--;
                if (rc[i] == 0 && !dead[i]) done[i] = 1'b1;
            end
        end
    endtask

    task automatic edge_pulse();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) step();
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_start(input int k);
        for (int i = 0; i < 100 && !start[k]; i++) step();
        chk("wait_start", start[k], 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) rc[i] = 0;
        done = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_vec(input vec_t v);
        int k, last_t, nfd;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        sched_en = v.en;
        btn1 = v.b1;
        btn2 = v.b2;
        eff = v.e;
        dead = v.dead;
        edge_pulse();
        chk("first_start", start, {3'b000, v.en});
        chk("busy_at_start", busy, v.en);
        chk("btn1_snap", btn1_snap, v.xb1);
        chk("btn2_snap", btn2_snap, v.xb2);
        chk("eff_snap", eff_snap, v.xe);
        k = (start != 0) ? 1 : 0;
        last_t = 0;
        nfd = 0;
        for (int t = 1; t < 300 && busy; t++) begin
            step();
            if (start != 0) begin
                chk("start_order", start, 4'b0001 << k);
                if (k > 0 && k < 4) chk("start_gap", t - last_t, v.dead[k-1] ? 17 : 4);
                last_t = t;
                k++;
            end
            if (frame_done) begin
                nfd++;
                chk("fd_gap", t - last_t, v.dead[3] ? 17 : 4);
            end
        end
        chk("frame_end_idle", busy, 0);
        if (!v.en)
            for (int t = 0; t < 5; t++) begin
                step();
                chk("disabled_busy", {busy, start}, 0);
            end
        chk("n_starts", k, v.en ? 4 : 0);
        chk("n_frame_done", nfd, v.en ? 1 : 0);
        chk("frame_cnt", frame_cnt, v.xcnt);
        chk("timeout_err", timeout_err, |v.dead);
        chk("err_unit", err_unit, v.xeu);
        chk("snap_hold", {btn1_snap, btn2_snap, eff_snap}, {v.xb1, v.xb2, v.xe});
        dead = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b10, 2'b01, 1'b1, 4'b0000, 2'b10, 2'b01, 1'b1, 16'd1, 2'd0};
        vecs[1] = '{1'b1, 2'b01, 2'b11, 1'b0, 4'b0100, 2'b01, 2'b11, 1'b0, 16'd2, 2'd2};
        vecs[2] = '{1'b0, 2'b11, 2'b00, 1'b1, 4'b0000, 2'b01, 2'b11, 1'b0, 16'd2, 2'd0};
        vecs[3] = '{1'b1, 2'b11, 2'b10, 1'b1, 4'b1001, 2'b11, 2'b10, 1'b1, 16'd3, 2'd3};
        vecs[4] = '{1'b1, 2'b00, 2'b00, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b0, 16'd4, 2'd0};
        for (int i = 0; i < 4; i++) rc[i] = 0;
        step();
        step();
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_snaps", {btn1_snap, btn2_snap, eff_snap}, 0);
        chk("rst_flags", {overrun, ovr_cnt, timeout_err, err_unit}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // overrun edges while unit 1 is in WAIT, then same-cycle clear vs set
        dead = 4'b0100;
        sched_en = 1'b1;
        btn1 = 2'b10;
        btn2 = 2'b01;
        eff = 1'b1;
        edge_pulse();
        wait_start(1);
        step();
        step();
        btn1 = 2'b01;
        btn2 = 2'b10;
        eff = 1'b0;
        edge_pulse();
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt1", ovr_cnt, 1);
        chk("ovr_snaps", {btn1_snap, btn2_snap, eff_snap}, {2'b10, 2'b01, 1'b1});
        chk("ovr_busy", busy, 1);
        step();
        edge_pulse();
        chk("ovr_cnt2", ovr_cnt, 2);
        step();
        clear_err = 1'b1;
        edge_pulse();
        clear_err = 1'b0;
        chk("clr_set_flag", overrun, 1);
        chk("clr_set_cnt", ovr_cnt, 1);
        wait_idle();
        chk("ovr_frame_cnt", frame_cnt, 5);
        chk("ovr_timeout", {timeout_err, err_unit}, {1'b1, 2'd2});
        dead = '0;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("cleared", {overrun, ovr_cnt, timeout_err, err_unit}, 0);

        // sched_en dropped mid-frame
        sched_en = 1'b1;
        edge_pulse();
        wait_start(1);
        sched_en = 1'b0;
        wait_idle();
        chk("en_drop_cnt", frame_cnt, 6);

        // async reset while start[1] is high
        sched_en = 1'b1;
        edge_pulse();
        wait_start(1);
        rst_n = 1'b0;
        #1;
        chk("async_start", start, 0);
        chk("async_busy", busy, 0);
        chk("async_cnt", frame_cnt, 0);
        for (int i = 0; i < 4; i++) rc[i] = 0;
        done = '0;
        step();
        rst_n = 1'b1;
        step();
        run_vec('{1'b1, 2'b10, 2'b10, 1'b0, 4'b0000, 2'b10, 2'b10, 1'b0, 16'd1, 2'd0});

        // ovr_cnt saturation: long all-timeout frames with an edge every other cycle
        do_reset();
        dead = 4'hF;
        sched_en = 1'b1;
        for (int i = 0; i < 320; i++) begin
            edge_pulse();
            step();
        end
        chk("ovr_sat", ovr_cnt, 255);
        chk("ovr_sat_flag", overrun, 1);
        wait_idle();
        dead = '0;

        // frame counter wrap on the 4-bit instance
        do_reset();
        sched_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            edge_pulse();
            wait_idle();
        end
        chk("cnt15", frame_cnt, 15);
        chk("small_cnt15", s_frame_cnt, 15);
        edge_pulse();
        wait_idle();
        chk("cnt16", frame_cnt, 16);
        chk("small_wrap", s_frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_update_sched.md
Name: frame_update_sched

Overview:
- Per-frame game-update scheduler sitting between the top-level input conditioning (debouncers, VGA sync) and the game-logic units inside the graphics/game datapath.
- On each vertical-sync falling edge it snapshots the debounced player inputs.
- It then sequences the update units (hero-1 physics, hero-2 physics, collision, scene scroll) one at a time with a start/done handshake, so the renderer always reads a consistent state.
- It flags frame overruns and hung units.

Parameters:
- NUM_UNITS, 4, number of sequenced update units; served in index order 0..NUM_UNITS-1.
- TIMEOUT, 4096, maximum WAIT cycles per unit before forced advance (>=2).
- FCW, 16, frame counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vsync  in  1  VGA vertical sync, active low, synchronous to clk.
- sched_en  in  1  level enable; when low, new frames are not started.
- btn1  in  2  debounced player-1 buttons.
- btn2  in  2  debounced player-2 buttons.
- eff  in  1  debounced effect button.
- done  in  NUM_UNITS  per-unit completion pulse/level.
- clear_err  in  1  clears sticky error flags.
- start  out  NUM_UNITS  one-hot one-cycle start strobe.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last unit completes.
- frame_cnt  out  FCW  completed-frame count; wraps.
- btn1_snap  out  2  player-1 buttons latched at frame start.
- btn2_snap  out  2  player-2 buttons latched at frame start.
- eff_snap  out  1  effect button latched at frame start.
- overrun  out  1  sticky: a vsync edge arrived while busy.
- ovr_cnt  out  8  saturating count of dropped edges.
- timeout_err  out  1  sticky: a unit exceeded TIMEOUT.
- err_unit  out  clog2(NUM_UNITS)  index of the most recent timed-out unit.

Behaviour:
- Reset:
  - Async assert forces all outputs and state to 0 and the FSM to IDLE, including mid-sequence.
  - start clears immediately.
  - Release is synchronous to clk.
- Edge detect: vsync_d register (reset value 1). An edge is a cycle where vsync_d=1 and vsync=0.
- FSM states: IDLE, START, WAIT, FIN.
- IDLE:
  - Edge with sched_en=1 -> START with idx=0; snapshots btn1/btn2/eff on the same clock.
  - Edge with sched_en=0 is ignored; no flag.
- START:
  - start[idx]=1 for exactly this cycle; timeout counter cleared; -> WAIT.
  - Latency: edge in cycle E gives start[0] and updated snapshots visible in E+1.
- WAIT:
  - done[idx] is sampled from the first WAIT cycle onward; done[idx] coinciding with start[idx] is ignored.
  - done[idx]=1 -> idx==NUM_UNITS-1 ? FIN : idx+1, START. Next start appears one cycle after done is seen.
  - No done for TIMEOUT WAIT cycles -> timeout_err=1, err_unit=idx, advance exactly as if done.
  - done and timeout in the same cycle: done wins, no error.
  - done bits of non-current units are ignored.
- FIN: frame_done=1 for one cycle; frame_cnt+1 (wraps at 2^FCW-1 -> 0); -> IDLE.
- Overrun:
  - Edge in START/WAIT/FIN sets overrun and increments ovr_cnt, saturating at 255.
  - The running sequence is not disturbed and the edge is dropped; snapshots are unchanged.
- sched_en falling mid-sequence: the current frame completes normally.
- clear_err=1 zeroes overrun, ovr_cnt, timeout_err and err_unit. If a set event occurs in the same cycle, the set wins (flag=1, ovr_cnt=1).
- Exactly one start bit is ever high, and only in START.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits).
  - Unit index constants UNIT_HERO1=0, UNIT_HERO2=1, UNIT_COLLIDE=2, UNIT_SCROLL=3.
  - Default TIMEOUT.
- One natural sub-module: unit_watchdog, the per-unit timeout counter with clear, enable and expire pulse.

Test Plan (NUM_UNITS=4, TIMEOUT=16):
1. Reset, btn1=2'b10, vsync 1->0 at cycle E; each done[i] returned 3 cycles after start[i].
   -> start[0] at E+1, btn1_snap=2'b10 at E+1; start[1..3] follow in sequence; frame_done pulses once; frame_cnt=1.
2. Unit 2 never asserts done.
   -> after 16 WAIT cycles: timeout_err=1, err_unit=2, start[3] next cycle; frame_done still pulses.
3. Second vsync edge while in WAIT on unit 1.
   -> overrun=1, ovr_cnt=1, btn snapshots unchanged; the sequence completes; then clear_err -> all flags 0.
4. sched_en=0 at the edge.
   -> no start and busy stays 0. Separately, sched_en dropped mid-frame -> the frame completes, frame_cnt increments.
5. rst_n asserted while start[1]=1.
   -> start=0, busy=0 and frame_cnt=0 immediately; the next edge after release starts at unit 0.
6. 300 dropped edges -> ovr_cnt saturates at 255. Separately, preload frame_cnt to 16'hFFFF and complete a frame -> frame_cnt=0.
